// File: rtl/kyp_scan_ctrl.sv
// PmodKYP 4x4 keypad scanner: column drive, row sampling,
// frame-based debounce and one-shot key code delivery.
module kyp_scan_ctrl #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic       clk,
    input  logic       sys_rst,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DWELL_ONE  = CW'(1);
    localparam logic [DW-1:0] DCNT_LAST  = DW'(DEBOUNCE_FRAMES - 1);
    localparam logic [DW-1:0] DCNT_ONE   = DW'(1);

    typedef enum logic [1:0] {IDLE, PRESS, HELD, RELEASE} state_e;

    logic [3:0]    row_s1_q, row_s2_q;
    logic [CW-1:0] dwell_q, dwell_d;
    logic [3:0]    col_q, col_d;
    logic [1:0]    cidx_q, cidx_d;
    logic          f_any_q, f_any_d;
    logic          f_multi_q, f_multi_d;
    logic [3:0]    f_code_q, f_code_d;
    state_e        state_q, state_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [3:0]    cand_q, cand_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          key_held_q, key_held_d;

    logic [3:0] low;
    logic [2:0] nlow;
    logic [1:0] ridx;
    logic       sample, frame_end;
    logic       s_any, s_multi, one, none;
    logic [3:0] s_code;

    function automatic logic [3:0] key_map(input logic [1:0] c,
                                           input logic [1:0] r);
        logic [3:0] k;
        case ({c, r})
            4'h0: k = 4'h1;
            4'h1: k = 4'h4;
            4'h2: k = 4'h7;
            4'h3: k = 4'h0;
            4'h4: k = 4'h2;
            4'h5: k = 4'h5;
            4'h6: k = 4'h8;
            4'h7: k = 4'hF;
            4'h8: k = 4'h3;
            4'h9: k = 4'h6;
            4'hA: k = 4'h9;
            4'hB: k = 4'hE;
            4'hC: k = 4'hA;
            4'hD: k = 4'hB;
            4'hE: k = 4'hC;
            default: k = 4'hD;
        endcase
        return k;
    endfunction

    always_comb begin
        low  = ~row_s2_q;
        nlow = {2'b00, low[0]} + {2'b00, low[1]}
             + {2'b00, low[2]} + {2'b00, low[3]};
        ridx = 2'd0;
        if (low[3])      ridx = 2'd0;
        else if (low[2]) ridx = 2'd1;
        else if (low[1]) ridx = 2'd2;
        else if (low[0]) ridx = 2'd3;

        sample    = (dwell_q == DWELL_LAST);
        frame_end = sample && (cidx_q == 2'd3);

        // accumulator view including the sample taken this cycle
        s_any   = f_any_q;
        s_multi = f_multi_q;
        s_code  = f_code_q;
        if (nlow > 3'd1) begin
            s_multi = 1'b1;
        end else if (nlow == 3'd1) begin
            if (f_any_q) s_multi = 1'b1;
            s_any  = 1'b1;
            s_code = key_map(cidx_q, ridx);
        end
        one  = s_any && !s_multi;
        none = !s_any && !s_multi;

        dwell_d     = dwell_q + DWELL_ONE;
        col_d       = col_q;
        cidx_d      = cidx_q;
        f_any_d     = f_any_q;
        f_multi_d   = f_multi_q;
        f_code_d    = f_code_q;
        state_d     = state_q;
        dcnt_d      = dcnt_q;
        cand_d      = cand_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;

        if (sample) begin
            dwell_d   = '0;
            col_d     = {col_q[0], col_q[3:1]};
            cidx_d    = cidx_q + 2'd1;
            f_any_d   = s_any;
            f_multi_d = s_multi;
            f_code_d  = s_code;
        end

        if (frame_end) begin
            f_any_d   = 1'b0;
            f_multi_d = 1'b0;
            f_code_d  = 4'h0;
            unique case (state_q)
                IDLE: begin
                    if (one) begin
                        if (DEBOUNCE_FRAMES == 1) begin
                            state_d     = HELD;
                            cand_d      = s_code;
                            key_code_d  = s_code;
                            key_valid_d = 1'b1;
                            key_held_d  = 1'b1;
                            dcnt_d      = '0;
                        end else begin
                            state_d = PRESS;
                            cand_d  = s_code;
                            dcnt_d  = DCNT_ONE;
                        end
                    end
                end
                PRESS: begin
                    if (!one) begin
                        state_d = IDLE;
                        dcnt_d  = '0;
                    end else if (s_code != cand_q) begin
                        cand_d = s_code;
                        dcnt_d = DCNT_ONE;
                    end else if (dcnt_q == DCNT_LAST) begin
                        state_d     = HELD;
                        key_code_d  = cand_q;
                        key_valid_d = 1'b1;
                        key_held_d  = 1'b1;
                        dcnt_d      = '0;
                    end else begin
                        dcnt_d = dcnt_q + DCNT_ONE;
                    end
                end
                HELD: begin
                    if (none) begin
                        if (DEBOUNCE_FRAMES == 1) begin
                            state_d    = IDLE;
                            key_held_d = 1'b0;
                            dcnt_d     = '0;
                        end else begin
                            state_d = RELEASE;
                            dcnt_d  = DCNT_ONE;
                        end
                    end
                end
                RELEASE: begin
                    if (!none) begin
                        state_d = HELD;
                        dcnt_d  = '0;
                    end else if (dcnt_q == DCNT_LAST) begin
                        state_d    = IDLE;
                        key_held_d = 1'b0;
                        dcnt_d     = '0;
                    end else begin
                        dcnt_d = dcnt_q + DCNT_ONE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            row_s1_q    <= 4'hF;
            row_s2_q    <= 4'hF;
            dwell_q     <= '0;
            col_q       <= 4'b0111;
            cidx_q      <= 2'd0;
            f_any_q     <= 1'b0;
            f_multi_q   <= 1'b0;
            f_code_q    <= 4'h0;
            state_q     <= IDLE;
            dcnt_q      <= '0;
            cand_q      <= 4'h0;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            row_s1_q    <= row_n;
            row_s2_q    <= row_s1_q;
            dwell_q     <= dwell_d;
            col_q       <= col_d;
            cidx_q      <= cidx_d;
            f_any_q     <= f_any_d;
            f_multi_q   <= f_multi_d;
            f_code_q    <= f_code_d;
            state_q     <= state_d;
            dcnt_q      <= dcnt_d;
            cand_q      <= cand_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign col_n     = col_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_kyp_scan_ctrl.sv
// Bench for kyp_scan_ctrl: keypad model, directed press patterns,
// scoreboard of expected key_valid pulses checked by a monitor.
module tb_kyp_scan_ctrl;

    localparam int SD = 4;
    localparam int DF = 3;
    localparam int FRAME = 4 * SD;

    logic       clk;
    logic       sys_rst;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [15:0] mask;
    int          cyc;
    int          n_chk;
    int          n_fail;

    typedef struct {
        logic [3:0] code;
        int         cyc;
    } exp_t;
    exp_t sb[$];

    kyp_scan_ctrl #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DF)) dut (
        .clk      (clk),
        .sys_rst  (sys_rst),
        .row_n    (row_n),
        .col_n    (col_n),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] kmap(input int c, input int r);
        logic [15:0] rows;
        case (c)
            0:       rows = 16'h1470;
            1:       rows = 16'h258F;
            2:       rows = 16'h369E;
            default: rows = 16'hABCD;
        endcase
        return rows[15-4*r -: 4];
    endfunction

    always_comb begin
        row_n = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (!col_n[3-c] && mask[kmap(c, r)])
                    row_n[3-r] = 1'b0;
    end

    always @(posedge clk) begin
        if (sys_rst) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    // monitor: column sequence and scoreboard of key_valid pulses
    always @(negedge clk) begin
        logic [3:0] oh;
        exp_t       e;
        if (!sys_rst) begin
            oh = 4'b1000 >> ((cyc / SD) % 4);
            n_chk++;
            if (col_n !== ~oh) begin
                n_fail++;
                $display("FAIL col_seq cyc=%0d got=%b want=%b",
                         cyc, col_n, ~oh);
            end
            if (key_valid === 1'b1) begin
                n_chk++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL extra_valid cyc=%0d got code=%h want no pulse",
                             cyc, key_code);
                end else begin
                    e = sb.pop_front();
                    if (key_code !== e.code || cyc != e.cyc) begin
                        n_fail++;
                        $display("FAIL pulse got code=%h cyc=%0d want code=%h cyc=%0d",
                                 key_code, cyc, e.code, e.cyc);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic run(input int frames);
        repeat (frames * FRAME) @(negedge clk);
    endtask

    task automatic expect_pulse(input logic [3:0] code, input int fr3);
        exp_t e;
        e.code = code;
        e.cyc  = FRAME * (fr3 + 1);
        sb.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        mask    = 16'h0;
        sys_rst = 1'b1;
        repeat (3) @(negedge clk);
        sys_rst = 1'b0;
        repeat (6) @(negedge clk);
        #2 sys_rst = 1'b1;
        #1;
        chk("rst_col", {4'h0, col_n}, 8'h07);
        chk("rst_code", {4'h0, key_code}, 8'h00);
        chk("rst_valid", {7'h0, key_valid}, 8'h00);
        chk("rst_held", {7'h0, key_held}, 8'h00);
        repeat (2) @(negedge clk);
        sys_rst = 1'b0;

        // frames 0-1 idle
        run(2);
        chk("idle_code", {4'h0, key_code}, 8'h00);
        chk("idle_held", {7'h0, key_held}, 8'h00);

        // "9" pressed for frames 2..6
        mask = 16'h0200;
        expect_pulse(4'h9, 4);
        run(5);
        chk("p9_code", {4'h0, key_code}, 8'h09);
        chk("p9_held", {7'h0, key_held}, 8'h01);
        mask = 16'h0;
        run(2);
        chk("p9_rel_held_mid", {7'h0, key_held}, 8'h01);
        run(1);
        chk("p9_rel_held", {7'h0, key_held}, 8'h00);

        // bounce frames 10..15, steady F from 16
        for (int i = 0; i < 6; i++) begin
            mask = (i % 2 == 0) ? 16'h8000 : 16'h0000;
            run(1);
        end
        mask = 16'h8000;
        expect_pulse(4'hF, 18);
        run(4);
        chk("pF_code", {4'h0, key_code}, 8'h0F);
        chk("pF_held", {7'h0, key_held}, 8'h01);
        mask = 16'h0;
        run(3);
        chk("pF_rel_held", {7'h0, key_held}, 8'h00);

        // "1" and "2" together, frames 23..28
        mask = 16'h0006;
        run(6);
        chk("multi_code", {4'h0, key_code}, 8'h0F);
        chk("multi_held", {7'h0, key_held}, 8'h00);
        mask = 16'h0;
        run(1);

        // "A" from frame 30, switch to "B" at 34
        mask = 16'h0400;
        expect_pulse(4'hA, 32);
        run(4);
        chk("pA_code", {4'h0, key_code}, 8'h0A);
        mask = 16'h0800;
        run(3);
        chk("swB_code", {4'h0, key_code}, 8'h0A);
        chk("swB_held", {7'h0, key_held}, 8'h01);
        mask = 16'h0;
        run(3);
        chk("swB_rel_held", {7'h0, key_held}, 8'h00);
        mask = 16'h0800;
        expect_pulse(4'hB, 42);
        run(3);
        chk("pB_code", {4'h0, key_code}, 8'h0B);
        chk("pB_held", {7'h0, key_held}, 8'h01);
        mask = 16'h0;
        run(3);

        // "5" from frame 46, 2-frame dropout at 50..51
        mask = 16'h0020;
        expect_pulse(4'h5, 48);
        run(4);
        chk("p5_held", {7'h0, key_held}, 8'h01);
        mask = 16'h0;
        run(1);
        chk("p5_drop1_held", {7'h0, key_held}, 8'h01);
        run(1);
        chk("p5_drop2_held", {7'h0, key_held}, 8'h01);
        mask = 16'h0020;
        run(3);
        chk("p5_back_held", {7'h0, key_held}, 8'h01);
        chk("p5_code", {4'h0, key_code}, 8'h05);
        mask = 16'h0;
        run(3);
        chk("p5_rel_held", {7'h0, key_held}, 8'h00);

        chk("sb_empty", 8'(sb.size()), 8'h00);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/kyp_scan_ctrl.md
# kyp_scan_ctrl

Scan controller for the 4x4 PmodKYP keypad. Drives the column lines one at a time, samples the row lines, debounces over whole scan frames, and delivers one debounced hex key code per press with a single-cycle valid strobe. Sits between the keypad pins and the LED display stage, which consumes `key_code`.

## Interface
- `SCAN_DIV`, 1000: clock cycles each column is held active; must be ≥ 4.
- `DEBOUNCE_FRAMES`, 4: consecutive qualifying frames needed to accept a press or a release; must be ≥ 1.
- `clk`  in  1  system clock.
- `sys_rst`  in  1  asynchronous, active-high reset.
- `row_n`  in  4  keypad rows, active-low, asynchronous to `clk`.
- `col_n`  out  4  keypad column drive, active-low, exactly one bit low at all times.
- `key_code`  out  4  last accepted key, held until the next accepted press.
- `key_valid`  out  1  one-cycle pulse when `key_code` is updated.
- `key_held`  out  1  high while the accepted key is considered pressed.

## Operation
- `row_n` passes through a 2-FF synchronizer before any use.
- Column sequence: `0111 → 1011 → 1101 → 1110 → 0111 …`. Each column is held for `SCAN_DIV` cycles, set by a dwell counter from 0 to `SCAN_DIV-1`.
- The synchronized rows are sampled when dwell = `SCAN_DIV-1`. Four samples make one frame.
- Frame result:
  - NONE: no row low in any column.
  - ONE(code): exactly one row/column intersection low.
  - MULTI: any other case, including two rows low in one column.
- Key map, listed as row_n 0111/1011/1101/1110:
  - col 0111 → 1/4/7/0
  - col 1011 → 2/5/8/F
  - col 1101 → 3/6/9/E
  - col 1110 → A/B/C/D
- The FSM is evaluated once per frame end. It uses a debounce counter `dcnt` and a candidate code `cand`.
  - IDLE:
    - ONE(c) → PRESS, with `cand`=c and `dcnt`=1.
    - NONE or MULTI → stay in IDLE.
  - PRESS:
    - ONE(c) with c=`cand` → `dcnt`+1.
    - ONE(c) with c≠`cand` → `cand`=c, `dcnt`=1.
    - NONE or MULTI → IDLE.
    - When `dcnt` reaches `DEBOUNCE_FRAMES`: go to HELD, load `key_code`=`cand`, pulse `key_valid`, set `key_held`.
    - With `DEBOUNCE_FRAMES`=1, the first ONE frame goes from IDLE straight to HELD.
  - HELD:
    - Any ONE or MULTI frame → stay in HELD.
    - NONE → RELEASE, `dcnt`=1.
    - No rollover: a different key while HELD is ignored until a full release.
  - RELEASE:
    - NONE → `dcnt`+1; at `DEBOUNCE_FRAMES` go to IDLE and clear `key_held`.
    - ONE or MULTI → back to HELD; `key_held` stays high.
- Reset mid-scan: the in-progress frame is discarded. After reset, scanning restarts at column `0111` with dwell 0.

## Timing
- Reset values:
  - `col_n`=0111, `key_code`=0, `key_valid`=0, `key_held`=0
  - FSM=IDLE, dwell=0, `dcnt`=0
- Frame length: 4·`SCAN_DIV` cycles. The frame end is the fourth sample cycle.
- The FSM updates in the same edge as the frame-end sample. `key_valid`, `key_code` and `key_held` change on the cycle after the frame-end sample cycle.
- `key_valid` is high for exactly one cycle per accepted press. It never asserts twice without an intervening release.
- Press latency, from the first sampled-pressed frame: `DEBOUNCE_FRAMES` frames plus 1 cycle, plus up to one partial frame.
- Input sync: 2 cycles. A row change is seen if it is stable from dwell ≤ `SCAN_DIV-3` of its column.
- `col_n` changes on the cycle after dwell = `SCAN_DIV-1`. It never glitches, and it never has zero or two bits low.

## Test plan
Bench parameters: `SCAN_DIV`=4, `DEBOUNCE_FRAMES`=3, so one frame is 16 cycles.

- Reset and idle: assert `sys_rst` mid-dwell, release it, keep `row_n`=1111.
  - Required: `col_n` cycles 0111/1011/1101/1110 at 4 cycles each.
  - Required: `key_valid` stays 0 and `key_code`=0.
- Single press "9": the keypad model pulls row_n[1]=0 while `col_n`=1101, for 5 frames.
  - Required: one `key_valid` pulse, 1 cycle after the 3rd qualifying frame end.
  - Required: `key_code`=9, `key_held`=1.
  - Release, then 3 NONE frames → `key_held`=0.
- Bounce: alternate press "F" / NONE every frame for 6 frames, then hold steady.
  - Required: no `key_valid` during the bounce.
  - Required: exactly one pulse with `key_code`=F, after the 3rd steady frame.
- Multi-key: press "1" and "2" together for 6 frames.
  - Required: no `key_valid`, FSM stays IDLE, `key_code` unchanged.
- Hold then switch: hold "A" until accepted, then switch to "B" with no gap.
  - Required: no new pulse while B is held.
  - Release B for 3 frames, press B for 3 frames → one pulse with `key_code`=B.
- Release glitch: while "5" is HELD, drop the key for 2 frames, then press it again.
  - Required: `key_held` stays 1 throughout.
  - Required: no second `key_valid`.
